// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial IF/MEM controller for the 8-bit unified RAM port
// Build option MEM_CTRL_IO_GUARD_EN adds io_buffer_full_i back-pressure on IO-region writes.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rdy_i,
    input  logic              flush_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              if_stall_o,
    output logic              mem_stall_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_a_o,
`ifdef MEM_CTRL_IO_GUARD_EN
    input  logic              io_buffer_full_i,
`endif
    output logic              ram_wr_o
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        i_q, i_d;
    logic [2:0]        c_q, c_d;
    logic              issued_q, issued_d;
    logic              is_if_q, is_if_d;
    logic              io_q, io_d;
    logic [ADDR_W-1:0] cur_addr;
    logic              io_byte;
    logic              io_hold;

    assign cur_addr = addr_q + ADDR_W'(i_q);

`ifdef MEM_CTRL_IO_GUARD_EN
    assign io_byte = (cur_addr[17:16] == 2'b11);
    assign io_hold = io_byte & io_buffer_full_i;
`else
    assign io_byte = 1'b0;
    assign io_hold = 1'b0;
`endif

    // One capture register serves both requesters; only one transaction is ever in flight.
    assign if_data_o   = data_q;
    assign mem_rdata_o = data_q;
    assign if_stall_o  = if_req_i & ~if_done_o;
    assign mem_stall_o = mem_req_i & ~mem_done_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            n_q      <= '0;
            i_q      <= '0;
            c_q      <= '0;
            issued_q <= 1'b0;
            is_if_q  <= 1'b0;
            io_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            n_q      <= n_d;
            i_q      <= i_d;
            c_q      <= c_d;
            issued_q <= issued_d;
            is_if_q  <= is_if_d;
            io_q     <= io_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        n_d        = n_q;
        i_d        = i_q;
        c_d        = c_q;
        issued_d   = 1'b0;
        is_if_d    = is_if_q;
        io_d       = io_q;
        ram_a_o    = '0;
        ram_dout_o = '0;
        ram_wr_o   = 1'b0;
        if_done_o  = 1'b0;
        mem_done_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (rdy_i && (mem_req_i || (if_req_i && !flush_i))) begin
                    i_d    = '0;
                    c_d    = '0;
                    data_d = '0;
                    io_d   = 1'b0;
                    if (mem_req_i) begin
                        state_d = mem_we_i ? MEM_WR : MEM_RD;
                        addr_d  = mem_addr_i;
                        wdata_d = mem_wdata_i;
                        is_if_d = 1'b0;
                        case (mem_size_i)
                            2'd0:    n_d = 3'd1;
                            2'd1:    n_d = 3'd2;
                            default: n_d = 3'd4;
                        endcase
                    end else begin
                        state_d = IF_RD;
                        addr_d  = if_addr_i;
                        is_if_d = 1'b1;
                        n_d     = 3'd4;
                    end
                end
            end
            IF_RD, MEM_RD: begin
                ram_a_o = cur_addr;
                if (rdy_i && (i_q < n_q)) begin
                    i_d      = i_q + 3'd1;
                    issued_d = 1'b1;
                end
                // ram_din_i answers last cycle's address, so capture trails issue by one.
                if (issued_q) begin
                    data_d[{c_q[1:0], 3'b000} +: 8] = ram_din_i;
                    c_d = c_q + 3'd1;
                    if (c_d == n_q) state_d = DONE;
                end
                if ((state_q == IF_RD) && flush_i) state_d = IDLE;
            end
            MEM_WR: begin
                ram_a_o    = cur_addr;
                ram_dout_o = wdata_q[{i_q[1:0], 3'b000} +: 8];
                if (rdy_i && !io_hold) begin
                    ram_wr_o = 1'b1;
                    i_d      = i_q + 3'd1;
                    io_d     = io_q | io_byte;
                    if (i_d == n_q) state_d = DONE;
                end
            end
            DONE: begin
                if (is_if_q) begin
                    if (flush_i) begin
                        state_d = IDLE;
                    end else if (rdy_i) begin
                        if_done_o = 1'b1;
                        state_d   = IDLE;
                    end
                end else if (rdy_i) begin
                    if (io_q) begin
                        io_d = 1'b0;
                    end else begin
                        mem_done_o = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard testbench for mem_ctrl against a byte-array reference model
`timescale 1ns/1ps
module tb_mem_ctrl;
    localparam int AW  = 32;
    localparam int MSZ = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b1;
    logic          flush = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [31:0]   if_data;
    logic          if_done;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [1:0]    mem_size = 2'd0;
    logic [AW-1:0] mem_addr = '0;
    logic [31:0]   mem_wdata = '0;
    logic [31:0]   mem_rdata;
    logic          mem_done;
    logic          if_stall;
    logic          mem_stall;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;
    logic [AW-1:0] ram_a;
    logic          ram_wr;
`ifdef MEM_CTRL_IO_GUARD_EN
    logic          io_full = 1'b0;
    int            io_until = 0;
`endif

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst), .rdy_i(rdy), .flush_i(flush),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_done_o(if_done),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_size_i(mem_size), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
        .if_stall_o(if_stall), .mem_stall_o(mem_stall),
        .ram_din_i(ram_din), .ram_dout_o(ram_dout), .ram_a_o(ram_a),
`ifdef MEM_CTRL_IO_GUARD_EN
        .io_buffer_full_i(io_full),
`endif
        .ram_wr_o(ram_wr)
    );

    logic [7:0] ram     [MSZ];
    logic [7:0] ref_mem [MSZ];
    bit         preload = 1'b0;

    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < MSZ; a++) ram[a] <= ref_mem[a];
        end else if (ram_wr) begin
            ram[ram_a[9:0]] <= ram_dout;
        end
        ram_din <= ram[ram_a[9:0]];
    end

    typedef struct {
        bit          is_if;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    string         mon_name;
    int            checks = 0;
    int            failures = 0;
    bit            hold_if = 1'b0;
    logic [AW-1:0] hold_if_addr = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && (if_done || mem_done)) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {30'd0, if_done, mem_done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_kind", {30'd0, if_done, mem_done}, mon_e.is_if ? 32'd2 : 32'd1);
                if (mon_e.chk) begin
                    if (mon_e.is_if) mon_name = "if_data";
                    else             mon_name = "mem_rdata";
                    chk(mon_name, mon_e.is_if ? if_data : mem_rdata, mon_e.data);
                end
            end
        end
    end

    task automatic run_txn(input bit is_if, input bit we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int flush_at, input int gap_lo, input int gap_hi, input bit rnd_rdy,
                           output int lat, output int nwr, output int first_wr);
        int          n;
        int          k;
        bit          done_seen;
        logic [31:0] exp_d;
        exp_t        e;
        string       sname;
        n     = is_if ? 4 : ((size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4);
        exp_d = '0;
        for (int j = 0; j < n; j++) begin
            if (we && !is_if) ref_mem[(addr + j) % MSZ] = wdata[8*j +: 8];
            else              exp_d[8*j +: 8] = ref_mem[(addr + j) % MSZ];
        end
        e.is_if = is_if;
        e.chk   = is_if || !we;
        e.data  = exp_d;
        sb.push_back(e);
        if (is_if) sname = "if_stall";
        else       sname = "mem_stall";
        lat = -1; nwr = 0; first_wr = -1; k = 0;
        @(posedge clk); #1;
        if_req = hold_if; if_addr = hold_if_addr; mem_req = 1'b0;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
        end
        forever begin
            flush = (k == flush_at);
            if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
            else         rdy = !(k >= gap_lo && k <= gap_hi);
`ifdef MEM_CTRL_IO_GUARD_EN
            io_full = (k < io_until);
`endif
            if (is_if && k == flush_at) void'(sb.pop_back());
            @(negedge clk);
            if (ram_wr) begin
                nwr++;
                if (first_wr < 0) first_wr = k;
            end
            done_seen = is_if ? if_done : mem_done;
            chk(sname, is_if ? {31'd0, if_stall} : {31'd0, mem_stall}, {31'd0, !done_seen});
            if (done_seen) begin
                lat = k;
                break;
            end
            if (is_if && k == flush_at) break;
            if (k >= 300) begin
                chk("txn_timeout", {31'd0, done_seen}, 32'd1);
                break;
            end
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic idle(input int cycles);
        @(posedge clk); #1;
        if_req = 1'b0; mem_req = 1'b0; flush = 1'b0; rdy = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, nwr, fw, bad;
        for (int a = 0; a < MSZ; a++) ref_mem[a] = 8'($urandom);
        ref_mem[32'h100] = 8'h13; ref_mem[32'h101] = 8'h05;
        ref_mem[32'h102] = 8'h00; ref_mem[32'h103] = 8'h00;
        ref_mem[32'h202] = 8'h5A;
        preload = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rst_if_done", {31'd0, if_done}, 32'd0);
        chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        preload = 1'b0;
        rst = 1'b0;

        run_txn(1'b1, 1'b0, 2'd0, 32'h100, 32'd0, -1, -1, -2, 1'b0, lat, nwr, fw);
        chk("if_fetch_latency", 32'(lat), 32'd6);
        chk("if_fetch_data_const", if_data, 32'h0000_0513);

        hold_if = 1'b1; hold_if_addr = 32'h0A0;
        run_txn(1'b0, 1'b0, 2'd2, 32'h040, 32'd0, -1, -1, -2, 1'b0, lat, nwr, fw);
        chk("simul_mem_latency", 32'(lat), 32'd6);
        hold_if = 1'b0;
        run_txn(1'b1, 1'b0, 2'd0, 32'h0A0, 32'd0, -1, -1, -2, 1'b0, lat, nwr, fw);
        chk("simul_if_latency", 32'(lat), 32'd6);

        run_txn(1'b0, 1'b1, 2'd1, 32'h200, 32'hAABBCCDD, -1, -1, -2, 1'b0, lat, nwr, fw);
        chk("half_store_latency", 32'(lat), 32'd3);
        chk("half_store_first_wr", 32'(fw), 32'd1);
        chk("half_store_nwr", 32'(nwr), 32'd2);
        chk("half_store_b0", {24'd0, ram[32'h200]}, 32'hDD);
        chk("half_store_b1", {24'd0, ram[32'h201]}, 32'hCC);
        chk("half_store_b2", {24'd0, ram[32'h202]}, 32'h5A);

        run_txn(1'b0, 1'b0, 2'd0, 32'h123, 32'd0, -1, -1, -2, 1'b0, lat, nwr, fw);
        chk("byte_load_latency", 32'(lat), 32'd3);

        run_txn(1'b0, 1'b0, 2'd2, 32'h2F0, 32'd0, -1, 3, 4, 1'b0, lat, nwr, fw);
        chk("rdy_gap_latency", 32'(lat), 32'd8);
        chk("rdy_gap_no_wr", 32'(nwr), 32'd0);

        run_txn(1'b1, 1'b0, 2'd0, 32'h180, 32'd0, 3, -1, -2, 1'b0, lat, nwr, fw);
        chk("flush_no_done", 32'(lat), 32'hFFFF_FFFF);
        run_txn(1'b1, 1'b0, 2'd0, 32'h1C4, 32'd0, -1, -1, -2, 1'b0, lat, nwr, fw);
        chk("post_flush_latency", 32'(lat), 32'd6);

        @(posedge clk); #1;
        if_req = 1'b0; flush = 1'b0; rdy = 1'b1;
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h300; mem_wdata = 32'h11223344;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstw_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rstw_ram_a", ram_a, 32'd0);
        chk("rstw_ram_dout", {24'd0, ram_dout}, 32'd0);
        chk("rstw_mem_done", {31'd0, mem_done}, 32'd0);
        chk("rstw_if_data", if_data, 32'd0);
        mem_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem[32'h300] = 8'h44;
        idle(1);

`ifdef MEM_CTRL_IO_GUARD_EN
        io_until = 3;
        run_txn(1'b0, 1'b1, 2'd0, 32'h30000, 32'h0000_00E7, -1, -1, -2, 1'b0, lat, nwr, fw);
        chk("io_first_wr", 32'(fw), 32'd3);
        chk("io_latency", 32'(lat), 32'd5);
        io_until = 0;
`endif

        for (int t = 0; t < 80; t++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_txn(kind == 0, kind == 2, 2'($urandom_range(0, 3)), 32'($urandom_range(0, MSZ - 5)),
                    $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1,
                    -1, -2, 1'b1, lat, nwr, fw);
        end

        idle(4);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        bad = 0;
        for (int a = 0; a < MSZ; a++) if (ram[a] !== ref_mem[a]) bad++;
        chk("mem_image", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the pipeline and the 8-bit unified RAM port. It serves instruction fetches from IF and loads/stores from MEM, one transaction at a time, with MEM given priority. It produces the `if_stall` and `mem_stall` request lines consumed by the stall controller, which holds them high until the transaction completes.

## Interface
Parameters:
- ADDR_W, 32, address width of all address ports.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  chip ready; low = hold (see Operation).
- flush  in  1  branch/jump flush; aborts an in-progress IF read.
- if_req  in  1  IF fetch request; held high until `if_done`.
- if_addr  in  ADDR_W  fetch address, stable while `if_req`.
- if_data  out  32  fetched instruction, valid while `if_done`.
- if_done  out  1  one-cycle completion pulse.
- mem_req  in  1  MEM access request; held high until `mem_done`.
- mem_we  in  1  1 = store, 0 = load.
- mem_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- mem_addr  in  ADDR_W  access address.
- mem_wdata  in  32  store data; low bytes are used.
- mem_rdata  out  32  load data, zero-extended; valid while `mem_done`.
- mem_done  out  1  one-cycle completion pulse.
- if_stall  out  1  `if_req & ~if_done`, combinational.
- mem_stall  out  1  `mem_req & ~mem_done`, combinational.
- ram_din  in  8  RAM read byte; it is the byte for the address driven in the previous cycle.
- ram_dout  out  8  RAM write byte.
- ram_a  out  ADDR_W  RAM byte address.
- ram_wr  out  1  1 = write.

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- **IDLE:**
  - If `mem_req` is high, go to MEM_RD or MEM_WR.
  - Otherwise, if `if_req` is high, go to IF_RD.
  - On acceptance, latch the address, the byte count N (IF: 4; MEM: 1/2/4) and the write data.
  - Clear the issue index i and the capture index c.
- **Read states:**
  - In each cycle with `rdy` high and i<N: drive `ram_a` = addr+i, then i++. Also set the registered flag `issued`, which records that an address was driven this cycle with `rdy` high.
  - In any cycle where `issued` (from the previous cycle) is set: capture `ram_din` into byte c, little-endian, then c++.
  - When c reaches N, go to DONE.
- **MEM_WR:**
  - In each cycle with `rdy` high and i<N: `ram_wr`=1, `ram_a`=addr+i, `ram_dout`=wdata byte i, then i++.
  - After byte N-1, go to DONE.
- **DONE:**
  - Pulse `if_done` or `mem_done` for exactly one cycle, with data valid.
  - New requests are ignored in this cycle. Return to IDLE.
- **`flush`:**
  - High in IF_RD or DONE-for-IF: abandon the fetch, go to IDLE next cycle, and suppress `if_done`.
  - Ignored in MEM states.
  - In IDLE, it blocks acceptance of `if_req` for that cycle.
- **`rdy` low:**
  - No issue, `ram_wr` forced 0, state and indices frozen.
  - The `issued` flag clears, so no stale capture occurs.
  - Outstanding captures resume when `rdy` returns high.
- **Reset:**
  - All state returns to IDLE immediately.
  - In-flight transactions are dropped; a partial write is left partial.
- **Reset values:** `ram_a`=0, `ram_dout`=0, `ram_wr`=0, `if_done`=0, `mem_done`=0, `if_data`=0, `mem_rdata`=0, i=c=0.

## Timing
- A request is accepted at the edge ending IDLE cycle T.
- **Read, no `rdy` gaps:**
  - Addresses are driven in T+1..T+N; bytes arrive in T+2..T+N+1.
  - The done pulse is in T+N+2. Word = 6 cycles after acceptance.
- **Write:**
  - Bytes are written in T+1..T+N; done in T+N+1.
- Each `rdy`-low cycle adds one cycle of latency.
- Back-to-back: the earliest next acceptance is in the cycle after DONE.
- Stall lines track requests combinationally. They fall in the done cycle, so the stall controller releases the pipeline on the same edge the data is latched.

## Configuration
- `MEM_CTRL_IO_GUARD_EN`:
  - **Defined:**
    - Adds input `io_buffer_full` (1 bit).
    - A write byte whose address has `addr[17:16]`==2'b11 is not issued while `io_buffer_full` is high (treated as `rdy` low for that byte).
    - After any such IO write, the controller inserts one idle cycle in DONE before returning to IDLE, so done is delayed by one cycle.
  - **Undefined:** the port is absent, and IO writes behave as normal writes.

## Test plan
- **IF word fetch:**
  - Stimulus: `if_addr`=0x100, RAM holds 13 05 00 00.
  - Required: `if_data`=0x00000513 with `if_done` at T+6, and `if_stall` high T..T+5.
- **Simultaneous requests:**
  - Stimulus: `if_req` and `mem_req` both high in IDLE.
  - Required: MEM served first, then IF accepted the cycle after `mem_done`.
- **Half store:**
  - Stimulus: `mem_addr`=0x200, `mem_wdata`=0xAABBCCDD.
  - Required: writes 0xDD@0x200 and 0xCC@0x201; 0x202 is untouched; done at T+3.
- **`rdy` gap:**
  - Stimulus: `rdy` low for 2 cycles mid-word-load.
  - Required: correct data, done delayed by 2 cycles, no `ram_wr`.
- **`flush` mid-fetch:**
  - Stimulus: `flush` at T+3.
  - Required: no `if_done`, IDLE at T+4, a new fetch is accepted normally.
- **Reset mid-write and IO guard:**
  - Stimulus: `rst` during a word write.
  - Required: outputs at reset values immediately.
  - Stimulus (`MEM_CTRL_IO_GUARD_EN` defined): byte store to 0x30000 with `io_buffer_full`=1 for 3 cycles.
  - Required: `ram_wr` asserted only after it falls.
